// File: rtl/xor_decrypt_rx_if.sv
`default_nettype none
// ============================================================================
// Module   : xor_decrypt_rx_if
// Brief    : Serial ciphertext input and plaintext byte handshake bundle.
// Revision : 1.0
// ============================================================================
interface xor_decrypt_rx_if #(
    parameter int KEY_SIZE = 32
);
    logic                iEn;
    logic [KEY_SIZE-1:0] iKey;
    logic                iKey_valid;
    logic                iSerial_in;
    logic                iSerial_start;
    logic                iSerial_end;
    logic [7:0]          oByte;
    logic                oByte_valid;
    logic                iByte_ready;
    logic                oFrame_done;
    logic                oFrame_error;
    logic                oOverflow;
    logic                oBusy;

    modport slave (
        input  iEn, iKey, iKey_valid, iSerial_in, iSerial_start, iSerial_end,
        input  iByte_ready,
        output oByte, oByte_valid, oFrame_done, oFrame_error, oOverflow, oBusy
    );

    modport master (
        output iEn, iKey, iKey_valid, iSerial_in, iSerial_start, iSerial_end,
        output iByte_ready,
        input  oByte, oByte_valid, oFrame_done, oFrame_error, oOverflow, oBusy
    );
endinterface
`default_nettype wire

// File: rtl/xor_decrypt_rx.sv
`default_nettype none
// ============================================================================
// Module   : xor_decrypt_rx
// Brief    : Framed serial XOR-cipher receiver with plaintext byte FIFO.
// Revision : 1.0
// ============================================================================
module xor_decrypt_rx #(
    parameter int MSG_SIZE   = 512,
    parameter int KEY_SIZE   = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              iClk,
    input  logic              iRst,
    xor_decrypt_rx_if.slave   bus
);
    localparam int CW = $clog2(MSG_SIZE);
    localparam int KW = (KEY_SIZE > 1) ? $clog2(KEY_SIZE) : 1;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int AW = PW + 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(MSG_SIZE - 1);
    localparam logic [KW-1:0] LAST_KEY = KW'(KEY_SIZE - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RECV = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [KW-1:0]       kidx_q, kidx_d;
    logic [KEY_SIZE-1:0] key_q, key_d;
    logic                key_loaded_q, key_loaded_d;
    logic [6:0]          sr_q, sr_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic                ovf_q, ovf_d;
    logic [AW-1:0]       wr_q, wr_d;
    logic [AW-1:0]       rd_q, rd_d;
    logic [7:0]          mem_q [FIFO_DEPTH];
    logic [7:0]          mem_d [FIFO_DEPTH];

    logic          take;
    logic [CW-1:0] idx;
    logic [KW-1:0] kidx;
    logic          plain;
    logic [7:0]    push_byte;
    logic          push;
    logic          pop;
    logic          full;
    logic          empty;

    always_comb begin
        state_d      = (state_q == S_DONE) ? S_IDLE : state_q;
        cnt_d        = cnt_q;
        kidx_d       = kidx_q;
        key_d        = key_q;
        key_loaded_d = key_loaded_q;
        sr_d         = sr_q;
        done_d       = 1'b0;
        err_d        = 1'b0;
        ovf_d        = ovf_q;
        wr_d         = wr_q;
        rd_d         = rd_q;
        mem_d        = mem_q;
        take         = 1'b0;
        idx          = cnt_q;
        kidx         = kidx_q;
        plain        = 1'b0;
        push_byte    = 8'h00;
        push         = 1'b0;

        empty = (wr_q == rd_q);
        full  = (wr_q[PW] != rd_q[PW]) && (wr_q[PW-1:0] == rd_q[PW-1:0]);
        pop   = !empty && bus.iByte_ready;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.iKey_valid) begin
                    key_d        = bus.iKey;
                    key_loaded_d = 1'b1;
                end
                if (bus.iEn && bus.iSerial_start) begin
                    if (key_loaded_q) begin
                        take  = 1'b1;
                        idx   = '0;
                        kidx  = '0;
                        ovf_d = 1'b0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_RECV: begin
                if (bus.iEn) begin
                    take = 1'b1;
                    // A start mid-frame aborts the old frame and restarts on this bit.
                    if (bus.iSerial_start) begin
                        err_d = 1'b1;
                        idx   = '0;
                        kidx  = '0;
                        ovf_d = 1'b0;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (take) begin
            plain     = bus.iSerial_in ^ key_q[kidx];
            push_byte = {plain, sr_q};
            sr_d      = {plain, sr_q[6:1]};
            push      = (idx[2:0] == 3'd7);
            cnt_d     = idx + CW'(1);
            kidx_d    = (kidx == LAST_KEY) ? '0 : kidx + KW'(1);
            state_d   = S_RECV;
            if (bus.iSerial_end || idx == LAST_IDX) begin
                cnt_d  = '0;
                kidx_d = '0;
                if (bus.iSerial_end && idx == LAST_IDX) begin
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end
            end
        end

        // A pop in the same cycle frees the slot, so a full FIFO still accepts.
        if (push) begin
            if (!full || pop) begin
                mem_d[wr_q[PW-1:0]] = push_byte;
                wr_d                = wr_q + AW'(1);
            end else begin
                ovf_d = 1'b1;
            end
        end
        if (pop) begin
            rd_d = rd_q + AW'(1);
        end
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            kidx_q       <= '0;
            key_q        <= '0;
            key_loaded_q <= 1'b0;
            sr_q         <= '0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            ovf_q        <= 1'b0;
            wr_q         <= '0;
            rd_q         <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= 8'h00;
            end
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            kidx_q       <= kidx_d;
            key_q        <= key_d;
            key_loaded_q <= key_loaded_d;
            sr_q         <= sr_d;
            done_q       <= done_d;
            err_q        <= err_d;
            ovf_q        <= ovf_d;
            wr_q         <= wr_d;
            rd_q         <= rd_d;
            mem_q        <= mem_d;
        end
    end

    assign bus.oByte        = (wr_q == rd_q) ? 8'h00 : mem_q[rd_q[PW-1:0]];
    assign bus.oByte_valid  = (wr_q != rd_q);
    assign bus.oFrame_done  = done_q;
    assign bus.oFrame_error = err_q;
    assign bus.oOverflow    = ovf_q;
    assign bus.oBusy        = (state_q == S_RECV);
endmodule
`default_nettype wire

// File: tb/tb_xor_decrypt_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_xor_decrypt_rx
// Brief    : Directed self-checking bench for xor_decrypt_rx (32-bit frames).
// Revision : 1.0
// ============================================================================
module tb_xor_decrypt_rx;
    logic        clk = 1'b0;
    logic        rst;
    logic        en, sin, sst, sen, kv, rdy;
    logic [31:0] key_a;
    logic [7:0]  key_b;

    int checks = 0;
    int fails  = 0;
    int done_a = 0, err_a = 0, done_b = 0, err_b = 0, both_a = 0;
    logic [7:0] qa[$];
    logic [7:0] qb[$];

    xor_decrypt_rx_if #(.KEY_SIZE(32)) if_a ();
    xor_decrypt_rx_if #(.KEY_SIZE(8))  if_b ();

    assign if_a.iEn = en;  assign if_a.iSerial_in = sin;  assign if_a.iSerial_start = sst;
    assign if_a.iSerial_end = sen;  assign if_a.iKey_valid = kv;  assign if_a.iByte_ready = rdy;
    assign if_a.iKey = key_a;
    assign if_b.iEn = en;  assign if_b.iSerial_in = sin;  assign if_b.iSerial_start = sst;
    assign if_b.iSerial_end = sen;  assign if_b.iKey_valid = kv;  assign if_b.iByte_ready = rdy;
    assign if_b.iKey = key_b;

    xor_decrypt_rx #(.MSG_SIZE(32), .KEY_SIZE(32), .FIFO_DEPTH(2)) dut_a (
        .iClk(clk), .iRst(rst), .bus(if_a));
    xor_decrypt_rx #(.MSG_SIZE(32), .KEY_SIZE(8), .FIFO_DEPTH(4)) dut_b (
        .iClk(clk), .iRst(rst), .bus(if_b));

    always #5 clk = ~clk;

    // Capture popped bytes and pulse counts away from the active edge.
    always @(negedge clk) begin
        if (if_a.oByte_valid && rdy) qa.push_back(if_a.oByte);
        if (if_b.oByte_valid && rdy) qb.push_back(if_b.oByte);
        if (if_a.oFrame_done)  done_a++;
        if (if_a.oFrame_error) err_a++;
        if (if_b.oFrame_done)  done_b++;
        if (if_b.oFrame_error) err_b++;
        if (if_a.oFrame_done && if_a.oFrame_error) both_a++;
    end

    typedef struct {
        logic [31:0] key;
        logic [31:0] cipher;
        logic [31:0] exp_a;
        logic [31:0] exp_b;
    } vec_t;
    vec_t vecs [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] ga(input int k);
        return (k < qa.size()) ? qa[k] : 8'hxx;
    endfunction
    function automatic logic [7:0] gb(input int k);
        return (k < qb.size()) ? qb[k] : 8'hxx;
    endfunction
    function automatic logic [31:0] pa(input int n);
        return {ga(n+3), ga(n+2), ga(n+1), ga(n)};
    endfunction
    function automatic logic [31:0] pb(input int n);
        return {gb(n+3), gb(n+2), gb(n+1), gb(n)};
    endfunction
    function automatic logic [12:0] outs_a();
        return {if_a.oByte, if_a.oByte_valid, if_a.oFrame_done, if_a.oFrame_error,
                if_a.oOverflow, if_a.oBusy};
    endfunction

    task automatic drive(input logic e, input logic b, input logic s, input logic t);
        en = e; sin = b; sst = s; sen = t;
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic load_keys(input logic [31:0] ka, input logic [7:0] kb);
        key_a = ka; key_b = kb; kv = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        kv = 1'b0;
    endtask

    task automatic send_range(input logic [31:0] c, input int lo, input int hi,
                              input logic st_first, input int end_at);
        for (int i = lo; i <= hi; i++) begin
            drive(1'b1, c[i], st_first && (i == lo), i == end_at);
        end
    endtask

    // Three non-sample cycles carrying junk flags and a mid-frame key write.
    task automatic gap3();
        logic [31:0] sa;
        logic [7:0]  sb;
        sa = key_a; sb = key_b;
        key_a = 32'h0; key_b = 8'h0; kv = 1'b1;
        repeat (3) drive(1'b0, 1'b1, 1'b1, 1'b1);
        kv = 1'b0; key_a = sa; key_b = sb;
    endtask

    int na, nb, d0, e0, db0, eb0;
    task automatic snap();
        na = qa.size(); nb = qb.size();
        d0 = done_a; e0 = err_a; db0 = done_b; eb0 = err_b;
    endtask

    localparam logic [31:0] C0 = 32'hCC99E897;

    initial begin
        vecs[0] = '{32'hDEADBEEF, 32'hCC99E897, 32'h12345678, 32'h23760778};
        vecs[1] = '{32'h000000A5, 32'hA5A5A5A5, 32'hA5A5A500, 32'h00000000};
        vecs[2] = '{32'h000000A5, 32'h5A5A5A5A, 32'h5A5A5AFF, 32'hFFFFFFFF};
        vecs[3] = '{32'hFFFFFFFF, 32'h0F0F0F0F, 32'hF0F0F0F0, 32'hF0F0F0F0};
        vecs[4] = '{32'h12345678, 32'h12345678, 32'h00000000, 32'h6A4C2E00};

        rst = 1'b1; en = 0; sin = 0; sst = 0; sen = 0; kv = 0; rdy = 1'b1;
        key_a = '0; key_b = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("reset_outs_a", 32'(outs_a()), 32'h0);

        // Start before any key load.
        snap();
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        idle(2);
        check("nokey_err", err_a - e0, 1);
        check("nokey_bytes", qa.size() - na, 0);
        check("nokey_busy", if_a.oBusy, 0);

        for (int v = 0; v < 5; v++) begin
            load_keys(vecs[v].key, vecs[v].key[7:0]);
            snap();
            send_range(vecs[v].cipher, 0, 31, 1'b1, 31);
            idle(3);
            check($sformatf("vec%0d_bytes_a", v), pa(na), vecs[v].exp_a);
            check($sformatf("vec%0d_bytes_b", v), pb(nb), vecs[v].exp_b);
            check($sformatf("vec%0d_done_a", v), done_a - d0, 1);
            check($sformatf("vec%0d_err_a", v), err_a - e0, 0);
            check($sformatf("vec%0d_done_b", v), done_b - db0, 1);
            check($sformatf("vec%0d_busy", v), if_a.oBusy, 0);
        end

        // Backpressure on the 2-deep FIFO drops the last two bytes.
        load_keys(32'hDEADBEEF, 8'hEF);
        rdy = 1'b0;
        snap();
        send_range(C0, 0, 31, 1'b1, 31);
        idle(2);
        check("ovf_flag", if_a.oOverflow, 1);
        check("ovf_done", done_a - d0, 1);
        check("ovf_head", {if_a.oByte_valid, if_a.oByte}, 9'h178);
        check("ovf_b_clear", if_b.oOverflow, 0);
        rdy = 1'b1;
        idle(4);
        check("ovf_count", qa.size() - na, 2);
        check("ovf_kept", {ga(na+1), ga(na)}, 16'h5678);
        check("ovf_sticky", if_a.oOverflow, 1);
        send_range(C0, 0, 0, 1'b1, -1);
        check("ovf_cleared", if_a.oOverflow, 0);
        send_range(C0, 1, 31, 1'b0, 31);
        idle(3);

        // Early end on bit 15.
        snap();
        send_range(C0, 0, 15, 1'b1, 15);
        idle(3);
        check("early_err", err_a - e0, 1);
        check("early_done", done_a - d0, 0);
        check("early_bytes", {16'h0, ga(na+1), ga(na)}, 32'h5678);
        check("early_count", qa.size() - na, 2);

        // No end flag by the last bit.
        snap();
        send_range(C0, 0, 31, 1'b1, -1);
        idle(3);
        check("noend_err", err_a - e0, 1);
        check("noend_done", done_a - d0, 0);
        check("noend_busy", if_a.oBusy, 0);

        // Restart on bit 20, then a full frame completes.
        snap();
        send_range(C0, 0, 19, 1'b1, -1);
        send_range(C0, 0, 31, 1'b1, 31);
        idle(3);
        check("restart_err", err_a - e0, 1);
        check("restart_done", done_a - d0, 1);
        check("restart_count", qa.size() - na, 6);
        check("restart_bytes", pa(na + 2), 32'h12345678);

        // Non-sample cycles mid-byte, with an ignored key write.
        snap();
        send_range(C0, 0, 10, 1'b1, -1);
        gap3();
        send_range(C0, 11, 31, 1'b0, 31);
        idle(3);
        check("gap_bytes_a", pa(na), 32'h12345678);
        check("gap_bytes_b", pb(nb), 32'h23760778);
        check("gap_done", done_a - d0, 1);
        check("gap_err", err_a - e0, 0);

        // Reset at bit 17 with bytes held in the FIFO.
        rdy = 1'b0;
        send_range(C0, 0, 16, 1'b1, -1);
        snap();
        rst = 1'b1;
        drive(1'b1, C0[17], 1'b0, 1'b0);
        rst = 1'b0;
        check("rst_outs_a", 32'(outs_a()), 32'h0);
        check("rst_valid_b", if_b.oByte_valid, 0);
        rdy = 1'b1;
        idle(3);
        check("rst_pulses", (done_a - d0) + (err_a - e0), 0);
        check("rst_bytes", qa.size() - na, 0);
        load_keys(32'hDEADBEEF, 8'hEF);
        snap();
        send_range(C0, 0, 31, 1'b1, 31);
        idle(3);
        check("post_rst_bytes", pa(na), 32'h12345678);
        check("post_rst_done", done_a - d0, 1);

        check("done_err_exclusive", both_a, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
`default_nettype wire
